dmem_responder: RTL and testbench

Data-memory responder for the MEM stage: the memory-side end of the load/store request interface issued by the pipeline. It accepts one request at a time, models a configurable number of wait states, and performs byte, half and word stores with lane strobes. Loads return extracted, sign- or zero-extended data. While a request is outstanding it raises a stall request to the control unit, so the pipeline holds MEM and upstream.

---
 rtl/dmem_responder.sv | 206 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding byte/half/word load or store with lane strobes and sign/zero-extended loads.
// Latency: RESP entered WaitStates edges after the accepting edge; response visible WaitStates+1 cycles after the request cycle.
// Backpressure: req_ready low from accept until RESP drains; RESP holds data/error stable while rsp_ready is low.
module dmem_responder #(
    parameter int Width      = 32,
    parameter int Depth      = 1024,
    parameter int WaitStates = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [Width-1:0] req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [Width-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [Width-1:0] rsp_data,
    output logic             rsp_error,
    output logic             stallreq
);
    localparam int         AW       = $clog2(Depth);
    localparam bit         NoWait   = (WaitStates == 0);
    localparam logic [3:0] WaitLoad = 4'(WaitStates);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    logic [3:0]       cnt;
    logic             lat_we;
    logic             lat_uns;
    logic [1:0]       lat_size;
    logic [Width-1:0] lat_addr;
    logic [Width-1:0] lat_wdata;

    logic [Width-1:0] mem [Depth];

    // With zero wait states the access completes on the accepting edge, so the live request is the operation.
    logic             op_we;
    logic             op_uns;
    logic [1:0]       op_size;
    logic [Width-1:0] op_addr;
    logic [Width-1:0] op_wdata;

    always_comb begin
        if (state == IDLE) begin
            op_we    = req_we;
            op_uns   = req_unsigned;
            op_size  = req_size;
            op_addr  = req_addr;
            op_wdata = req_wdata;
        end else begin
            op_we    = lat_we;
            op_uns   = lat_uns;
            op_size  = lat_size;
            op_addr  = lat_addr;
            op_wdata = lat_wdata;
        end
    end

    logic [AW-1:0] op_idx;
    logic          misaligned;
    logic          illegal;
    logic          out_of_range;
    logic          op_err;

    assign op_idx       = op_addr[AW+1:2];
    assign misaligned   = ((op_size == 2'd1) && op_addr[0]) ||
                          ((op_size == 2'd2) && (op_addr[1:0] != 2'b00));
    assign illegal      = (op_size == 2'd3);
    assign out_of_range = (op_addr[Width-1:2] >= (Width-2)'(Depth));
    assign op_err       = misaligned || illegal || out_of_range;

    logic [3:0]       strobe;
    logic [Width-1:0] wr_lanes;

    always_comb begin
        strobe   = 4'b0000;
        wr_lanes = op_wdata;
        case (op_size)
            2'd0: begin
                strobe   = 4'b0001 << op_addr[1:0];
                wr_lanes = {4{op_wdata[7:0]}};
            end
            2'd1: begin
                strobe   = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{op_wdata[15:0]}};
            end
            2'd2: begin
                strobe   = 4'b1111;
                wr_lanes = op_wdata;
            end
            default: begin
                strobe   = 4'b0000;
                wr_lanes = op_wdata;
            end
        endcase
    end

    logic [Width-1:0] rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [Width-1:0] ld_val;
    logic [Width-1:0] rsp_next;

    always_comb begin
        rd_word = mem[op_idx];
        case (op_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = op_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (op_size)
            2'd0:    ld_val = {{24{!op_uns && rd_byte[7]}}, rd_byte};
            2'd1:    ld_val = {{16{!op_uns && rd_half[15]}}, rd_half};
            default: ld_val = rd_word;
        endcase
    end

    assign rsp_next = (op_err || op_we) ? '0 : ld_val;

    logic enter_resp;
    assign enter_resp = ((state == IDLE) && req_valid && NoWait) ||
                        ((state == WAIT) && (cnt == 4'd1));

    // Array has no reset; gating on rst drops a store whose RESP edge coincides with reset.
    always_ff @(posedge clk) begin
        if (rst && enter_resp && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (strobe[b]) begin
                    mem[op_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            lat_we    <= 1'b0;
            lat_uns   <= 1'b0;
            lat_size  <= 2'd0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_size  <= req_size;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        cnt       <= WaitLoad;
                        req_ready <= 1'b0;
                        if (NoWait) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= rsp_next;
                            rsp_error <= op_err;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= rsp_next;
                        rsp_error <= op_err;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_data  <= '0;
                        rsp_error <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign stallreq = rst && (((state == IDLE) && req_valid) ||
                              (state == WAIT) ||
                              ((state == RESP) && !rsp_ready));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: vector table, reset/back-pressure sequences, and random traffic against a byte-level memory model.
module tb_dmem_responder;
    localparam int WS = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_error, stallreq;
    logic [31:0] rsp_data;

    logic        req_valid0, req_ready0, req_we0, req_unsigned0;
    logic [31:0] req_addr0, req_wdata0;
    logic [1:0]  req_size0;
    logic        rsp_valid0, rsp_ready0, rsp_error0, stallreq0;
    logic [31:0] rsp_data0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [7:0] mb [4096];

    always #5 clk = ~clk;

    dmem_responder #(.Width(32), .Depth(1024), .WaitStates(WS)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_error(rsp_error), .stallreq(stallreq)
    );

    dmem_responder #(.Width(32), .Depth(1024), .WaitStates(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we0),
        .req_addr(req_addr0), .req_size(req_size0), .req_unsigned(req_unsigned0),
        .req_wdata(req_wdata0), .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
        .rsp_data(rsp_data0), .rsp_error(rsp_error0), .stallreq(stallreq0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference: memory as a flat byte array, accesses as little-endian byte runs.
    function automatic void model(input bit we, input logic [31:0] a, input logic [1:0] sz,
                                  input bit uns, input logic [31:0] wd,
                                  output logic [31:0] d, output bit e);
        int unsigned n;
        logic [31:0] v;
        n = 1 << sz;
        e = (sz == 2'd3) || ((a % n) != 0) || (a >= 32'd4096);
        d = 32'h0;
        if (e) return;
        if (we) begin
            for (int i = 0; i < int'(n); i++) mb[a + i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < int'(n); i++) v = v | (32'(mb[a + i]) << (8 * i));
            if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
            d = v;
        end
    endfunction

    // Entry/exit: #1 after a rising edge, DUT idle, req_valid low.
    task automatic do_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                          input bit uns, input logic [31:0] wdata, input int hold,
                          output logic [31:0] data, output bit err);
        int lat;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata; rsp_ready = (hold == 0);
        #1;
        check("stall_on_req", 32'(stallreq), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
        req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            check("wait_ready", 32'(req_ready), 32'd0);
            check("wait_stall", 32'(stallreq), 32'd1);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(WS + 1));
        data = rsp_data;
        err  = rsp_error;
        for (int i = 0; i < hold; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            check("bp_stall", 32'(stallreq), 32'd1);
            check("bp_data", rsp_data, data);
            check("bp_err", 32'(rsp_error), 32'(err));
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("resp_stall_rel", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        check("idle_ready", 32'(req_ready), 32'd1);
        check("idle_valid", 32'(rsp_valid), 32'd0);
    endtask

    task automatic txn0(input string name, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                        input logic [31:0] exp_d, input bit exp_e);
        req_valid0 = 1'b1; req_we0 = we; req_addr0 = addr; req_size0 = size;
        req_unsigned0 = uns; req_wdata0 = wdata;
        @(posedge clk); #1;
        req_valid0 = 1'b0;
        check({name, "_valid"}, 32'(rsp_valid0), 32'd1);
        check({name, "_data"}, rsp_data0, exp_d);
        check({name, "_err"}, 32'(rsp_error0), 32'(exp_e));
        @(posedge clk); #1;
        check({name, "_idle"}, 32'(req_ready0), 32'd1);
    endtask

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [1:0]  size;
        bit          uns;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t tv [22];

    initial begin
        logic [31:0] a, wd, d, ed;
        logic [1:0]  sz;
        bit          we, uns, e, ee;
        int          hold;

        tv[0]  = '{1'b1, 32'h020, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0};
        tv[1]  = '{1'b0, 32'h020, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0};
        tv[2]  = '{1'b1, 32'h020, 2'd2, 1'b0, 32'h00000000, 32'h00000000, 1'b0};
        tv[3]  = '{1'b1, 32'h021, 2'd0, 1'b0, 32'h00000080, 32'h00000000, 1'b0};
        tv[4]  = '{1'b0, 32'h021, 2'd0, 1'b0, 32'h0,        32'hFFFFFF80, 1'b0};
        tv[5]  = '{1'b0, 32'h021, 2'd0, 1'b1, 32'h0,        32'h00000080, 1'b0};
        tv[6]  = '{1'b0, 32'h020, 2'd2, 1'b0, 32'h0,        32'h00008000, 1'b0};
        tv[7]  = '{1'b0, 32'h022, 2'd2, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tv[8]  = '{1'b1, 32'h023, 2'd1, 1'b0, 32'h0000FFFF, 32'h00000000, 1'b1};
        tv[9]  = '{1'b0, 32'h020, 2'd3, 1'b0, 32'h0,        32'h00000000, 1'b1};
        tv[10] = '{1'b1, 32'h020, 2'd3, 1'b0, 32'h12345678, 32'h00000000, 1'b1};
        tv[11] = '{1'b0, 32'h020, 2'd2, 1'b0, 32'h0,        32'h00008000, 1'b0};
        tv[12] = '{1'b0, 32'h1000, 2'd2, 1'b0, 32'h0,       32'h00000000, 1'b1};
        tv[13] = '{1'b1, 32'h022, 2'd1, 1'b0, 32'h0000A55A, 32'h00000000, 1'b0};
        tv[14] = '{1'b0, 32'h022, 2'd1, 1'b0, 32'h0,        32'hFFFFA55A, 1'b0};
        tv[15] = '{1'b0, 32'h022, 2'd1, 1'b1, 32'h0,        32'h0000A55A, 1'b0};
        tv[16] = '{1'b0, 32'h020, 2'd2, 1'b1, 32'h0,        32'hA55A8000, 1'b0};
        tv[17] = '{1'b1, 32'hFFC, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 1'b0};
        tv[18] = '{1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0,        32'h11223344, 1'b0};
        tv[19] = '{1'b0, 32'hFFF, 2'd0, 1'b1, 32'h0,        32'h00000011, 1'b0};
        tv[20] = '{1'b1, 32'h1000, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h00000000, 1'b1};
        tv[21] = '{1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0,        32'h11223344, 1'b0};

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h0; rsp_ready = 1'b1;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_addr0 = 32'h0; req_size0 = 2'd0;
        req_unsigned0 = 1'b0; req_wdata0 = 32'h0; rsp_ready0 = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_stallreq", 32'(stallreq), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int w = 0; w < 64; w++) begin
            model(1'b1, 32'(w * 4), 2'd2, 1'b0, 32'h0, ed, ee);
            do_txn(1'b1, 32'(w * 4), 2'd2, 1'b0, 32'h0, 0, d, e);
        end

        // Reset lands while a store to 0x10 is still waiting: it must never reach the array.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("midwait_stall", 32'(stallreq), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_stallreq", 32'(stallreq), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("postrst_req_ready", 32'(req_ready), 32'd1);
        check("postrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("postrst_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        do_txn(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, d, e);
        check("dropped_store_data", d, 32'h0);
        check("dropped_store_err", 32'(e), 32'd0);

        for (int i = 0; i < 22; i++) begin
            model(tv[i].we, tv[i].addr, tv[i].size, tv[i].uns, tv[i].wdata, ed, ee);
            do_txn(tv[i].we, tv[i].addr, tv[i].size, tv[i].uns, tv[i].wdata, 0, d, e);
            check($sformatf("vec%0d_data", i), d, tv[i].exp_data);
            check($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].exp_err));
        end

        // Consumer stalls three cycles in RESP.
        do_txn(1'b0, 32'h020, 2'd2, 1'b0, 32'h0, 3, d, e);
        check("bp_load_data", d, 32'hA55A8000);
        check("bp_load_err", 32'(e), 32'd0);

        for (int n = 0; n < 300; n++) begin
            we   = 1'($urandom);
            uns  = 1'($urandom);
            sz   = 2'($urandom_range(0, 3));
            wd   = $urandom;
            hold = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = $urandom | 32'h1000;
            else a = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            model(we, a, sz, uns, wd, ed, ee);
            do_txn(we, a, sz, uns, wd, hold, d, e);
            check($sformatf("rnd%0d_data", n), d, ed);
            check($sformatf("rnd%0d_err", n), 32'(e), 32'(ee));
        end

        txn0("ws0_store", 1'b1, 32'h40, 2'd2, 1'b0, 32'h12345678, 32'h0, 1'b0);
        txn0("ws0_ldw", 1'b0, 32'h40, 2'd2, 1'b0, 32'h0, 32'h12345678, 1'b0);
        txn0("ws0_ldb", 1'b0, 32'h43, 2'd0, 1'b0, 32'h0, 32'h00000012, 1'b0);
        txn0("ws0_ldh", 1'b0, 32'h42, 2'd1, 1'b0, 32'h0, 32'h00001234, 1'b0);
        txn0("ws0_ldbu", 1'b0, 32'h40, 2'd0, 1'b1, 32'h0, 32'h00000078, 1'b0);
        txn0("ws0_oor", 1'b0, 32'h1000, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1);
        txn0("ws0_mis", 1'b0, 32'h41, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
